// File: rtl/alu_exec_stage.sv
// Execute-stage ALU slice: decodes the ALU operation and computes a 64-bit result with N/Z/V/C flags.
// The result, flags and forwarded control are captured each cycle into the EX/MEM pipeline register.
module alu_exec_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ALUOp,
    input  logic [10:0] OpcodeField,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [2:0]  MEM,
    input  logic [1:0]  WB,
    input  logic [63:0] brAddr,
    input  logic [63:0] ReadData2,
    input  logic [4:0]  Rw,
    output logic [63:0] result,
    output logic        negative,
    output logic        zero,
    output logic        overflow,
    output logic        carry_out,
    output logic [2:0]  cntrl,
    output logic [63:0] ALU_Result_Out,
    output logic [63:0] brAddr_Out,
    output logic [63:0] ReadData2_Out,
    output logic [2:0]  MEM_Out,
    output logic [1:0]  WB_Out,
    output logic [4:0]  Rw_Out,
    output logic        zero_Out,
    output logic        negative_Out,
    output logic        overflow_Out,
    output logic        carry_Out
);

    localparam logic [2:0] CTL_PASS_B = 3'b000;
    localparam logic [2:0] CTL_ADD    = 3'b010;
    localparam logic [2:0] CTL_SUB    = 3'b011;
    localparam logic [2:0] CTL_AND    = 3'b100;
    localparam logic [2:0] CTL_ORR    = 3'b101;
    localparam logic [2:0] CTL_EOR    = 3'b110;

    logic [2:0]  w_cntrl;
    logic [63:0] w_b_op;
    logic        w_cin;
    logic [63:0] w_low_sum;
    logic        w_c63;
    logic [63:0] w_sum;
    logic        w_cout;
    logic [63:0] w_result;
    logic        w_overflow;
    logic        w_carry;

    logic [63:0] r_alu_result;
    logic [63:0] r_br_addr;
    logic [63:0] r_read_data2;
    logic [2:0]  r_mem;
    logic [1:0]  r_wb;
    logic [4:0]  r_rw;
    logic        r_zero;
    logic        r_negative;
    logic        r_overflow;
    logic        r_carry;

    // ALU control decode from operation class and opcode
    always_comb begin
        w_cntrl = CTL_ADD;
        case (ALUOp)
            2'b00: w_cntrl = CTL_ADD;
            2'b01: w_cntrl = CTL_PASS_B;
            2'b11: w_cntrl = CTL_PASS_B;
            2'b10: begin
                casez (OpcodeField)
                    11'b10001011000: w_cntrl = CTL_ADD;
                    11'b10101011000: w_cntrl = CTL_ADD;
                    11'b11101011000: w_cntrl = CTL_SUB;
                    11'b10001010000: w_cntrl = CTL_AND;
                    11'b10101010000: w_cntrl = CTL_ORR;
                    11'b11001010000: w_cntrl = CTL_EOR;
                    11'b1001000100?: w_cntrl = CTL_ADD;
                    11'b11010011011: w_cntrl = CTL_PASS_B;
                    11'b11010011010: w_cntrl = CTL_PASS_B;
                    11'b10011011000: w_cntrl = CTL_PASS_B;
                    default:         w_cntrl = CTL_ADD;
                endcase
            end
            default: w_cntrl = CTL_ADD;
        endcase
    end

    // Shared adder; the low 63 bits are summed separately to expose the carry into bit 63
    always_comb begin
        w_cin     = (w_cntrl == CTL_SUB);
        w_b_op    = w_cin ? ~B : B;
        w_low_sum = {1'b0, A[62:0]} + {1'b0, w_b_op[62:0]} + {63'd0, w_cin};
        w_c63     = w_low_sum[63];
        w_sum     = {A[63] ^ w_b_op[63] ^ w_c63, w_low_sum[62:0]};
        w_cout    = (A[63] & w_b_op[63]) | (w_c63 & (A[63] ^ w_b_op[63]));
    end

    // Result select; arithmetic flags are only meaningful for add/sub
    always_comb begin
        w_result   = 64'd0;
        w_overflow = 1'b0;
        w_carry    = 1'b0;
        case (w_cntrl)
            CTL_PASS_B: w_result = B;
            CTL_ADD, CTL_SUB: begin
                w_result   = w_sum;
                w_overflow = w_c63 ^ w_cout;
                w_carry    = w_cout;
            end
            CTL_AND: w_result = A & B;
            CTL_ORR: w_result = A | B;
            CTL_EOR: w_result = A ^ B;
            default: w_result = 64'd0;
        endcase
    end

    assign cntrl     = w_cntrl;
    assign result    = w_result;
    assign negative  = w_result[63];
    assign zero      = (w_result == 64'd0);
    assign overflow  = w_overflow;
    assign carry_out = w_carry;

    // EX/MEM pipeline register, captures every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_result <= 64'd0;
            r_br_addr    <= 64'd0;
            r_read_data2 <= 64'd0;
            r_mem        <= 3'd0;
            r_wb         <= 2'd0;
            r_rw         <= 5'd0;
            r_zero       <= 1'b0;
            r_negative   <= 1'b0;
            r_overflow   <= 1'b0;
            r_carry      <= 1'b0;
        end else begin
            r_alu_result <= w_result;
            r_br_addr    <= brAddr;
            r_read_data2 <= ReadData2;
            r_mem        <= MEM;
            r_wb         <= WB;
            r_rw         <= Rw;
            r_zero       <= (w_result == 64'd0);
            r_negative   <= w_result[63];
            r_overflow   <= w_overflow;
            r_carry      <= w_carry;
        end
    end

    assign ALU_Result_Out = r_alu_result;
    assign brAddr_Out     = r_br_addr;
    assign ReadData2_Out  = r_read_data2;
    assign MEM_Out        = r_mem;
    assign WB_Out         = r_wb;
    assign Rw_Out         = r_rw;
    assign zero_Out       = r_zero;
    assign negative_Out   = r_negative;
    assign overflow_Out   = r_overflow;
    assign carry_Out      = r_carry;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed, table-driven bench for alu_exec_stage: combinational ALU/flags, EX/MEM capture and reset.
module tb_alu_exec_stage;

    logic        clk;
    logic        reset;
    logic [1:0]  ALUOp;
    logic [10:0] OpcodeField;
    logic [63:0] A, B, brAddr, ReadData2;
    logic [2:0]  MEM;
    logic [1:0]  WB;
    logic [4:0]  Rw;
    logic [63:0] result, ALU_Result_Out, brAddr_Out, ReadData2_Out;
    logic        negative, zero, overflow, carry_out;
    logic [2:0]  cntrl, MEM_Out;
    logic [1:0]  WB_Out;
    logic [4:0]  Rw_Out;
    logic        zero_Out, negative_Out, overflow_Out, carry_Out;

    int checks = 0;
    int errors = 0;

    alu_exec_stage dut (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .OpcodeField(OpcodeField),
        .A(A), .B(B), .MEM(MEM), .WB(WB), .brAddr(brAddr), .ReadData2(ReadData2), .Rw(Rw),
        .result(result), .negative(negative), .zero(zero), .overflow(overflow),
        .carry_out(carry_out), .cntrl(cntrl),
        .ALU_Result_Out(ALU_Result_Out), .brAddr_Out(brAddr_Out), .ReadData2_Out(ReadData2_Out),
        .MEM_Out(MEM_Out), .WB_Out(WB_Out), .Rw_Out(Rw_Out),
        .zero_Out(zero_Out), .negative_Out(negative_Out),
        .overflow_Out(overflow_Out), .carry_Out(carry_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_MUL  = 11'b10011011000;

    typedef struct {
        logic [1:0]  aluop;
        logic [10:0] op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  nzvc;
        logic [2:0]  ctl;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_out_zero(input string tag);
        chk({tag, " ALU_Result_Out"}, ALU_Result_Out, 64'd0);
        chk({tag, " brAddr_Out"}, brAddr_Out, 64'd0);
        chk({tag, " ReadData2_Out"}, ReadData2_Out, 64'd0);
        chk({tag, " MEM/WB/Rw_Out"}, {54'd0, MEM_Out, WB_Out, Rw_Out}, 64'd0);
        chk({tag, " flags_Out"}, {60'd0, negative_Out, zero_Out, overflow_Out, carry_Out}, 64'd0);
    endtask

    logic [63:0] s_a [5];
    logic [63:0] s_b [5];
    logic [64:0] s_sum;

    initial begin
        vecs[0]  = '{2'b10, OP_ADD,  64'd5, 64'd3, 64'd8, 4'b0000, 3'b010};
        vecs[1]  = '{2'b10, OP_SUBS, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 3'b011};
        vecs[2]  = '{2'b10, OP_SUBS, 64'd7, 64'd7, 64'd0, 4'b0101, 3'b011};
        vecs[3]  = '{2'b10, OP_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010, 3'b010};
        vecs[4]  = '{2'b10, OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0101, 3'b010};
        vecs[5]  = '{2'b10, OP_AND,  64'hF0F0, 64'hFF00, 64'hF000, 4'b0000, 3'b100};
        vecs[6]  = '{2'b10, OP_ORR,  64'hF0F0, 64'hFF00, 64'hFFF0, 4'b0000, 3'b101};
        vecs[7]  = '{2'b10, OP_EOR,  64'hF0F0, 64'hFF00, 64'h0FF0, 4'b0000, 3'b110};
        vecs[8]  = '{2'b10, OP_LSL,  64'hF0F0, 64'hFF00, 64'hFF00, 4'b0000, 3'b000};
        vecs[9]  = '{2'b01, OP_ADD,  64'd5, 64'd0, 64'd0, 4'b0100, 3'b000};
        vecs[10] = '{2'b00, OP_EOR,  64'h100, 64'd8, 64'h108, 4'b0000, 3'b010};
        vecs[11] = '{2'b10, OP_ADDI, 64'd10, 64'd20, 64'd30, 4'b0000, 3'b010};
        vecs[12] = '{2'b10, 11'b10010001001, 64'd100, 64'd23, 64'd123, 4'b0000, 3'b010};
        vecs[13] = '{2'b10, OP_ADDS, 64'd1, 64'd2, 64'd3, 4'b0000, 3'b010};
        vecs[14] = '{2'b10, OP_LSR,  64'd9, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b1000, 3'b000};
        vecs[15] = '{2'b10, OP_MUL,  64'd9, 64'd42, 64'd42, 4'b0000, 3'b000};
        vecs[16] = '{2'b10, 11'b11111111111, 64'd1, 64'd1, 64'd2, 4'b0000, 3'b010};
        vecs[17] = '{2'b11, OP_SUBS, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 3'b000};
        vecs[18] = '{2'b00, OP_SUBS, 64'd10, 64'd3, 64'd13, 4'b0000, 3'b010};
        vecs[19] = '{2'b10, OP_SUBS, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 3'b011};
        vecs[20] = '{2'b10, OP_SUBS, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 3'b011};

        reset = 1'b1; ALUOp = 2'b00; OpcodeField = 11'd0; A = 64'd0; B = 64'd0;
        MEM = 3'b111; WB = 2'b11; Rw = 5'd31; brAddr = 64'hDEAD; ReadData2 = 64'hBEEF;
        repeat (2) @(posedge clk);
        #1;
        chk_all_out_zero("reset_state");

        @(negedge clk);
        reset = 1'b0;
        MEM = 3'b000; WB = 2'b00; Rw = 5'd0; brAddr = 64'd0; ReadData2 = 64'd0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            ALUOp = vecs[i].aluop; OpcodeField = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            #1;
            chk($sformatf("v%0d result", i), result, vecs[i].res);
            chk($sformatf("v%0d nzvc", i), {60'd0, negative, zero, overflow, carry_out}, {60'd0, vecs[i].nzvc});
            chk($sformatf("v%0d cntrl", i), {61'd0, cntrl}, {61'd0, vecs[i].ctl});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ALU_Result_Out", i), ALU_Result_Out, vecs[i].res);
            chk($sformatf("v%0d nzvc_Out", i), {60'd0, negative_Out, zero_Out, overflow_Out, carry_Out},
                {60'd0, vecs[i].nzvc});
        end

        // control/data capture then one-edge reset
        @(negedge clk);
        ALUOp = 2'b10; OpcodeField = OP_ADD; A = 64'd5; B = 64'd3;
        MEM = 3'b101; WB = 2'b11; Rw = 5'd9; brAddr = 64'h40; ReadData2 = 64'h1234;
        @(posedge clk);
        #1;
        chk("cap ALU_Result_Out", ALU_Result_Out, 64'd8);
        chk("cap brAddr_Out", brAddr_Out, 64'h40);
        chk("cap ReadData2_Out", ReadData2_Out, 64'h1234);
        chk("cap MEM_Out", {61'd0, MEM_Out}, 64'd5);
        chk("cap WB_Out", {62'd0, WB_Out}, 64'd3);
        chk("cap Rw_Out", {59'd0, Rw_Out}, 64'd9);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("comb during reset", result, 64'd8);
        @(posedge clk);
        #1;
        chk_all_out_zero("mid_reset");
        chk("comb after reset edge", result, 64'd8);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset ALU_Result_Out", ALU_Result_Out, 64'd8);
        chk("post-reset MEM_Out", {61'd0, MEM_Out}, 64'd5);

        // streaming: each output reflects the previous edge's inputs
        for (int k = 0; k < 5; k++) begin
            s_a[k] = 64'h1111_0000_0000_0000 * (k + 1) + 64'(k * 7);
            s_b[k] = (k == 2) ? (~s_a[k] + 64'd1) : 64'hF000_0000_0000_0003 + 64'(k);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ALUOp = 2'b00; OpcodeField = OP_SUBS; A = s_a[k]; B = s_b[k];
            MEM = 3'(k); WB = 2'(k); Rw = 5'(k + 3);
            brAddr = 64'h1000 + 64'(k * 4); ReadData2 = 64'hA5A5 ^ 64'(k);
            @(posedge clk);
            #1;
            s_sum = {1'b0, s_a[k]} + {1'b0, s_b[k]};
            chk($sformatf("s%0d ALU_Result_Out", k), ALU_Result_Out, s_sum[63:0]);
            chk($sformatf("s%0d zero/carry_Out", k), {62'd0, zero_Out, carry_Out},
                {62'd0, (s_sum[63:0] == 64'd0), s_sum[64]});
            chk($sformatf("s%0d brAddr_Out", k), brAddr_Out, 64'h1000 + 64'(k * 4));
            chk($sformatf("s%0d ReadData2_Out", k), ReadData2_Out, 64'hA5A5 ^ 64'(k));
            chk($sformatf("s%0d ctl_Out", k), {54'd0, MEM_Out, WB_Out, Rw_Out},
                {54'd0, 3'(k), 2'(k), 5'(k + 3)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage datapath slice of the 64-bit pipelined ARM CPU. It decodes the ALU operation from `ALUOp` and the 11-bit opcode, and computes a 64-bit result with N/Z/V/C flags. It captures the result, flags, branch target, store data, destination register and downstream control into the EX/MEM pipeline register. It sits between the ID/EX register and data memory.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `ALUOp` in 2: ALU operation class from main control.
- `OpcodeField` in 11: `instr[31:21]` of the instruction in EX.
- `A` in 64: ALU operand A (forwarded Rn).
- `B` in 64: ALU operand B, already muxed: Rm, immediate, shifted value, product or address offset.
- `MEM` in 3: `{BrTaken, MemReadEn, MemWrite}`.
- `WB` in 2: `{RegWriteEn, MemToReg}`.
- `brAddr` in 64: computed branch target.
- `ReadData2` in 64: store data.
- `Rw` in 5: destination register.
- `result` out 64: combinational ALU result.
- `negative`, `zero`, `overflow`, `carry_out` out 1 each: combinational flags.
- `cntrl` out 3: combinational decoded ALU op, for debug.
- `ALU_Result_Out`, `brAddr_Out`, `ReadData2_Out` out 64 each: registered.
- `MEM_Out` out 3, `WB_Out` out 2, `Rw_Out` out 5: registered.
- `zero_Out`, `negative_Out`, `overflow_Out`, `carry_Out` out 1 each: registered flags.

## Operation
- **`ALUOp` decode to `cntrl`:**
  - `00` gives 010 (add), used for LDUR/STUR address.
  - `01` gives 000 (pass B), used for CBZ test.
  - `11` gives 000 (pass B).
  - `10` decodes `OpcodeField`:
    - ADD 10001011000 and ADDS 10101011000 give 010.
    - SUBS 11101011000 gives 011.
    - AND 10001010000 gives 100.
    - ORR 10101010000 gives 101.
    - EOR 11001010000 gives 110.
    - ADDI 1001000100x (bit 0 don't-care) gives 010.
    - LSL 11010011011, LSR 11010011010 and MUL 10011011000 give 000.
    - Any other opcode gives 010.
- **ALU ops by `cntrl`:**
  - 000: B.
  - 010: A+B.
  - 011: A−B, computed as A+~B+1.
  - 100: A&B.
  - 101: A|B.
  - 110: A^B.
  - 001 and 111: result 0.
- **Flags:**
  - `negative` = `result[63]`.
  - `zero` = (`result` == 0).
  - `carry_out` = carry out of bit 63 of the adder. For subtraction this is 1 when no borrow occurs.
  - `overflow` = carry into bit 63 XOR carry out of bit 63.
  - For non-add/sub ops, `carry_out` and `overflow` are 0.
- All arithmetic is 64-bit two's complement and wraps modulo 2^64.
- Flag-setting policy (ADDS/SUBS only) is applied by the consumer. This block always registers the flags of every op.

## Timing
- `cntrl`, `result` and the four flags are purely combinational from `ALUOp`, `OpcodeField`, `A` and `B`. There is zero latency.
- EX/MEM register: on each `clk` rising edge, every `*_Out` captures its input. `ALU_Result_Out` captures `result`, and the flag outputs capture the current flags.
- Latency is 1 cycle. There is no stall or enable; the register captures every cycle.
- Reset: a rising edge with `reset`=1 forces every registered output to 0.
  - This gives `MEM_Out`=000 and `WB_Out`=00: no branch, no memory access, no register write.
  - Reset overrides capture.
  - Reset asserted mid-stream clears the stage on that edge. The first post-reset capture is the inputs at the next edge with `reset`=0.
- Combinational outputs are not affected by reset.

## Test plan
- `ALUOp`=10, ADD opcode, A=5, B=3 → `result`=8, all flags 0. After one edge, `ALU_Result_Out`=8.
- SUBS, A=3, B=5 → `result`=0xFFFF_FFFF_FFFF_FFFE, N=1, Z=0, C=0, V=0. With A=7, B=7 → `result`=0, Z=1, C=1.
- ADD, A=0x7FFF_FFFF_FFFF_FFFF, B=1 → `result`=0x8000_0000_0000_0000, N=1, V=1, C=0. With A=all-ones, B=1 → `result`=0, Z=1, C=1, V=0.
- Logic ops with A=0xF0F0, B=0xFF00:
  - AND gives 0xF000.
  - ORR gives 0xFFF0.
  - EOR gives 0x0FF0.
  - LSL opcode gives `result`=B=0xFF00.
  - `ALUOp`=01 with B=0 gives Z=1.
  - `ALUOp`=00 with A=0x100, B=8 gives 0x108.
- Drive MEM=101, WB=11, Rw=9, brAddr=0x40, ReadData2=0x1234 → all appear on the `*_Out` outputs after the next edge. Assert `reset` for one edge → all `*_Out`=0 on that edge.
- Change inputs every cycle over 5 cycles → each `*_Out` equals the inputs present at the previous edge.
